// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU. Binary ops finish in one cycle;
// decimal add/subtract walks the operands one BCD digit per cycle, LSB first.
// Results and flags hold until the next operation completes.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             bcd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [3:0] OP_INC = 4'h0;
  localparam logic [3:0] OP_DEC = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_ROR = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_ROL = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_BIT = 4'h9;
  localparam logic [3:0] OP_EOR = 4'hA;
  localparam logic [3:0] OP_ONE = 4'hB;
  localparam logic [3:0] OP_LSR = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_BCD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;
  state_t w_launch;
  logic   w_accept;

  // Operands and per-operation context captured when start is accepted.
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [KW-1:0]    r_k;
  logic             r_cy;   // decimal carry (add) or borrow (sub)

  // Registered outputs.
  logic [WIDTH-1:0] r_y;
  logic             r_c;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic             r_busy;
  logic             r_done;

  // Binary datapath.
  logic [WIDTH-1:0] w_bin_a;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_low;
  logic             w_add_v;
  logic [WIDTH-1:0] w_bin_y;
  logic             w_bin_c;
  logic             w_bin_n;
  logic             w_bin_v;

  // Decimal digit datapath.
  logic [KW+1:0]    w_pos;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [3:0]       w_a_dig;
  logic [3:0]       w_b_dig;
  logic [4:0]       w_dsum;
  logic [4:0]       w_ddiff;
  logic [3:0]       w_dig;
  logic             w_cy_next;
  logic [WIDTH-1:0] w_bcd_y;
  logic             w_bcd_c;

  // Next-state logic: start accepted in IDLE and DONE only.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    if (bcd && ((op == OP_ADD) || (op == OP_SUB))) begin
      w_launch = S_BCD;
    end else begin
      w_launch = S_CALC;
    end
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = w_launch;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CALC: w_state_next = S_DONE;
      S_BCD: begin
        if (r_k == K_LAST) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_BCD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Binary sum shared by add/sub results and the V flag (also used in decimal mode).
  always_comb begin
    if (r_op == OP_SUB) begin
      w_bin_a = ~r_a;
    end else begin
      w_bin_a = r_a;
    end
    w_sum   = {1'b0, w_bin_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    w_low   = {1'b0, w_bin_a[WIDTH-2:0]} + {1'b0, r_b[WIDTH-2:0]}
              + {{(WIDTH-1){1'b0}}, r_cin};
    w_add_v = w_low[WIDTH-1] ^ w_sum[WIDTH];
  end

  // Single-cycle binary result, carry and flags.
  always_comb begin
    w_bin_y = {WIDTH{1'b0}};
    w_bin_c = 1'b0;
    case (r_op)
      OP_INC: {w_bin_c, w_bin_y} = {1'b0, r_a} + {{WIDTH{1'b0}}, r_cin};
      OP_DEC: {w_bin_c, w_bin_y} = {1'b0, r_a} - {{WIDTH{1'b0}}, r_cin};
      OP_ADD, OP_SUB: {w_bin_c, w_bin_y} = w_sum;
      OP_ROR: begin
        w_bin_y = {r_cin, r_a[WIDTH-1:1]};
        w_bin_c = r_a[0];
      end
      OP_ASL: begin
        w_bin_y = {r_a[WIDTH-2:0], 1'b0};
        w_bin_c = r_a[WIDTH-1];
      end
      OP_ROL: begin
        w_bin_y = {r_a[WIDTH-2:0], r_cin};
        w_bin_c = r_a[WIDTH-1];
      end
      OP_OR:  w_bin_y = r_a | r_b;
      OP_AND: w_bin_y = r_a & r_b;
      OP_BIT: w_bin_y = r_a & r_b;
      OP_EOR: w_bin_y = r_a ^ r_b;
      OP_ONE: begin
        w_bin_y = {WIDTH{1'b1}};
        w_bin_c = 1'b1;
      end
      OP_LSR: begin
        w_bin_y = {1'b0, r_a[WIDTH-1:1]};
        w_bin_c = r_a[0];
      end
      default: begin
        w_bin_y = {WIDTH{1'b0}};
        w_bin_c = 1'b0;
      end
    endcase
    w_bin_n = w_bin_y[WIDTH-1] | ((r_op == OP_BIT) & r_a[WIDTH-1]);
    case (r_op)
      OP_ADD, OP_SUB: w_bin_v = w_add_v;
      OP_BIT:         w_bin_v = r_a[WIDTH-2];
      default:        w_bin_v = 1'b0;
    endcase
  end

  // One decimal digit per cycle; digit k is spliced into the held result.
  always_comb begin
    w_pos     = {r_k, 2'b00};
    w_a_shift = r_a >> w_pos;
    w_b_shift = r_b >> w_pos;
    w_a_dig   = w_a_shift[3:0];
    w_b_dig   = w_b_shift[3:0];
    w_dsum    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_cy};
    w_ddiff   = {1'b0, w_b_dig} - {1'b0, w_a_dig} - {4'd0, r_cy};
    if (r_op == OP_SUB) begin
      if (w_ddiff[4]) begin
        w_dig     = w_ddiff[3:0] + 4'd10;
        w_cy_next = 1'b1;
      end else begin
        w_dig     = w_ddiff[3:0];
        w_cy_next = 1'b0;
      end
      w_bcd_c = ~w_cy_next;
    end else begin
      if (w_dsum > 5'd9) begin
        w_dig     = w_dsum[3:0] + 4'd6;
        w_cy_next = 1'b1;
      end else begin
        w_dig     = w_dsum[3:0];
        w_cy_next = 1'b0;
      end
      w_bcd_c = w_cy_next;
    end
    w_bcd_y = (r_y & ~({{(WIDTH-4){1'b0}}, 4'hF} << w_pos))
              | ({{(WIDTH-4){1'b0}}, w_dig} << w_pos);
  end

  // Operand capture, digit counter and decimal carry chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= 4'd0;
      r_a   <= {WIDTH{1'b0}};
      r_b   <= {WIDTH{1'b0}};
      r_cin <= 1'b0;
      r_k   <= {KW{1'b0}};
      r_cy  <= 1'b0;
    end else if (w_accept) begin
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
      r_cin <= c_in;
      r_k   <= {KW{1'b0}};
      r_cy  <= (op == OP_SUB) ? ~c_in : c_in;
    end else if (r_state == S_BCD) begin
      r_k  <= r_k + {{(KW-1){1'b0}}, 1'b1};
      r_cy <= w_cy_next;
    end else begin
      r_k  <= r_k;
      r_cy <= r_cy;
    end
  end

  // Result/flag registers and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y    <= {WIDTH{1'b0}};
      r_c    <= 1'b0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_v    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_CALC) || (w_state_next == S_BCD);
      r_done <= (w_state_next == S_DONE);
      if (r_state == S_CALC) begin
        r_y <= w_bin_y;
        r_c <= w_bin_c;
        r_z <= (w_bin_y == {WIDTH{1'b0}});
        r_n <= w_bin_n;
        r_v <= w_bin_v;
      end else if (r_state == S_BCD) begin
        // Partial digits are visible; flags only move with the last digit.
        r_y <= w_bcd_y;
        if (r_k == K_LAST) begin
          r_c <= w_bcd_c;
          r_z <= (w_bcd_y == {WIDTH{1'b0}});
          r_n <= w_bcd_y[WIDTH-1];
          r_v <= w_add_v;
        end else begin
          r_c <= r_c;
        end
      end else begin
        r_y <= r_y;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign y        = r_y;
  assign c_out    = r_c;
  assign zero     = r_z;
  assign negative = r_n;
  assign overflow = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

  typedef struct {
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance
  logic       rst8, start8, ci8, bcd8, busy8, done8, c8, z8, n8, v8;
  logic [3:0] op8;
  logic [7:0] a8, b8, y8;
  // WIDTH=16 instance
  logic        rst16, start16, ci16, bcd16, busy16, done16, c16, z16, n16, v16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, y16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .c_in(ci8), .bcd(bcd8), .busy(busy8), .done(done8), .y(y8),
    .c_out(c8), .zero(z8), .negative(n8), .overflow(v8));

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst16), .start(start16), .op(op16), .a(a16), .b(b16),
    .c_in(ci16), .bcd(bcd16), .busy(busy16), .done(done16), .y(y16),
    .c_out(c16), .zero(z16), .negative(n16), .overflow(v16));

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model written in plain integer arithmetic.
  function automatic exp_t model(input int w, input int op, input int a, input int b,
                                 input int cin, input int bcd);
    exp_t e;
    int full, half, r, c, v, sa, sb, s, cy, ak, bk, d;
    full = 1 << w; half = 1 << (w - 1);
    r = 0; c = 0; v = 0;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    case (op)
      0: begin r = a + cin; c = (r >= full) ? 1 : 0; end
      1: begin r = a - cin; c = (r < 0) ? 1 : 0; end
      2: begin r = a + b + cin; c = (r >= full) ? 1 : 0;
               s = sa + sb + cin; v = (s >= half || s < -half) ? 1 : 0; end
      3: begin r = b - a - (1 - cin); c = (r >= 0) ? 1 : 0;
               s = sb - sa - (1 - cin); v = (s >= half || s < -half) ? 1 : 0; end
      4: begin r = cin * half + (a >> 1); c = a & 1; end
      5: begin r = a * 2; c = a / half; end
      6: begin r = a * 2 + cin; c = a / half; end
      7: r = a | b;
      8: r = a & b;
      9: begin r = a & b; v = (a / (half / 2)) & 1; end
      10: r = a ^ b;
      11: begin r = full - 1; c = 1; end
      12: begin r = a >> 1; c = a & 1; end
      default: r = 0;
    endcase
    if (bcd != 0 && (op == 2 || op == 3)) begin
      r = 0;
      cy = (op == 2) ? cin : 1 - cin;
      for (int k = 0; k < w / 4; k++) begin
        ak = (a >> (4 * k)) & 15;
        bk = (b >> (4 * k)) & 15;
        if (op == 2) begin
          d = ak + bk + cy;
          if (d > 9) begin d = d + 6; cy = 1; end else cy = 0;
        end else begin
          d = bk - ak - cy;
          if (d < 0) begin d = d + 10; cy = 1; end else cy = 0;
        end
        r = r | ((d & 15) << (4 * k));
      end
      c = (op == 2) ? cy : 1 - cy;
    end
    r = r & (full - 1);
    e.y   = r[15:0];
    e.c   = c[0];
    e.z   = (r == 0) ? 1'b1 : 1'b0;
    e.n   = ((((r >> (w - 1)) & 1) == 1) || (op == 9 && ((a >> (w - 1)) & 1) == 1)) ? 1'b1 : 1'b0;
    e.v   = v[0];
    e.lat = (bcd != 0 && (op == 2 || op == 3)) ? w / 4 : 1;
    e.t0  = 0;
    return e;
  endfunction

  // Scoreboard pop for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check_val("unexpected_done8", {31'd0, done8}, 32'd0);
      end else begin
        e8 = q8.pop_front();
        check_val("y8",   {24'd0, y8}, {16'd0, e8.y});
        check_val("cvnz8", {28'd0, c8, v8, n8, z8}, {28'd0, e8.c, e8.v, e8.n, e8.z});
        check_val("lat8", cyc - e8.t0 - 1, e8.lat);
      end
    end
  end

  // Scoreboard pop for the 16-bit instance.
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        check_val("unexpected_done16", {31'd0, done16}, 32'd0);
      end else begin
        e16 = q16.pop_front();
        check_val("y16",   {16'd0, y16}, {16'd0, e16.y});
        check_val("cvnz16", {28'd0, c16, v16, n16, z16}, {28'd0, e16.c, e16.v, e16.n, e16.z});
        check_val("lat16", cyc - e16.t0 - 1, e16.lat);
      end
    end
  end

  task automatic issue8(input int op, input int a, input int b, input int cin, input int bcd);
    int tries = 0;
    exp_t e;
    @(negedge clk);
    while (busy8 && tries < 50) begin @(negedge clk); tries++; end
    if (tries >= 50) check_val("busy_timeout8", {31'd0, busy8}, 32'd0);
    op8 = op[3:0]; a8 = a[7:0]; b8 = b[7:0]; ci8 = cin[0]; bcd8 = bcd[0]; start8 = 1'b1;
    e = model(8, op, a, b, cin, bcd);
    e.t0 = cyc;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue16(input int op, input int a, input int b, input int cin, input int bcd);
    int tries = 0;
    exp_t e;
    @(negedge clk);
    while (busy16 && tries < 50) begin @(negedge clk); tries++; end
    if (tries >= 50) check_val("busy_timeout16", {31'd0, busy16}, 32'd0);
    op16 = op[3:0]; a16 = a[15:0]; b16 = b[15:0]; ci16 = cin[0]; bcd16 = bcd[0]; start16 = 1'b1;
    e = model(16, op, a, b, cin, bcd);
    e.t0 = cyc;
    q16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic drain8();
    int tries = 0;
    while (q8.size() != 0 && tries < 60) begin @(negedge clk); tries++; end
    check_val("drain8", q8.size(), 32'd0);
  endtask

  task automatic drain16();
    int tries = 0;
    while (q16.size() != 0 && tries < 60) begin @(negedge clk); tries++; end
    check_val("drain16", q16.size(), 32'd0);
  endtask

  initial begin
    rst8 = 1'b1; rst16 = 1'b1;
    start8 = 1'b0; op8 = 4'd0; a8 = 8'd0; b8 = 8'd0; ci8 = 1'b0; bcd8 = 1'b0;
    start16 = 1'b0; op16 = 4'd0; a16 = 16'd0; b16 = 16'd0; ci16 = 1'b0; bcd16 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_out8",  {16'd0, busy8, done8, c8, z8, n8, v8, 2'd0, y8}, 32'd0);
    check_val("rst_out16", {8'd0, busy16, done16, c16, z16, n16, v16, 2'd0, y16}, 32'd0);
    rst8 = 1'b0; rst16 = 1'b0;

    // Directed cases with fixed expectations.
    issue8(2, 'h50, 'h50, 0, 0); drain8();
    check_val("plan_add", {19'd0, c8, v8, n8, z8, 1'b0, y8}, {19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0});
    issue8(2, 'h58, 'h46, 1, 1); drain8();
    check_val("plan_bcd_add", {23'd0, c8, z8, y8}, {23'd0, 1'b1, 1'b0, 8'h05});
    issue8(3, 'h21, 'h12, 1, 1); drain8();
    check_val("plan_bcd_sub", {23'd0, c8, 1'b0, y8}, {23'd0, 1'b0, 1'b0, 8'h91});
    issue8(3, 'h01, 'h10, 1, 0); drain8();
    check_val("plan_sub", {23'd0, c8, 1'b0, y8}, {23'd0, 1'b1, 1'b0, 8'h0F});
    issue8(4, 'h01, 'h00, 1, 0); drain8();
    check_val("plan_ror", {22'd0, c8, n8, 1'b0, y8}, {22'd0, 1'b1, 1'b1, 1'b0, 8'h80});
    issue8(9, 'hC0, 'h00, 0, 0); drain8();
    check_val("plan_bit", {21'd0, z8, n8, v8, 1'b0, y8}, {21'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
    // Outputs hold between operations.
    repeat (3) @(negedge clk);
    check_val("hold_y8", {24'd0, y8}, 32'd0);

    // Every opcode, then back-to-back random traffic.
    for (int o = 0; o < 16; o++) issue8(o, 'hA5, 'h3C, o & 1, 0);
    for (int i = 0; i < 40; i++)
      issue8($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 1), $urandom_range(0, 1));
    drain8();

    // 16-bit decimal add with a start pulse ignored mid-operation.
    issue16(2, 'h0001, 'h9999, 0, 1);
    @(negedge clk);
    op16 = 4'd11; a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    drain16();
    check_val("plan_bcd16", {14'd0, c16, z16, y16}, {14'd0, 1'b1, 1'b1, 16'h0000});
    for (int i = 0; i < 12; i++)
      issue16($urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 65535),
              $urandom_range(0, 1), $urandom_range(0, 1));
    drain16();

    // Reset at digit 1 of a 16-bit decimal op: outputs clear, no done.
    issue16(3, 'h1234, 'h5678, 1, 1);
    @(negedge clk);
    rst16 = 1'b1;
    #1;
    check_val("midrst_out16", {8'd0, busy16, done16, c16, z16, n16, v16, 2'd0, y16}, 32'd0);
    q16.delete();
    repeat (2) @(negedge clk);
    rst16 = 1'b0;
    repeat (8) @(negedge clk);
    check_val("midrst_idle16", {31'd0, busy16}, 32'd0);
    issue16(2, 'h4567, 'h5555, 0, 1);
    drain16();
    check_val("post_rst16", {16'd0, y16}, {16'd0, 16'h0122});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the hmc-6502 combinational ALU. Adds a start/busy/done handshake and a generic `WIDTH`, and implements decimal (BCD) add/subtract as a nibble-serial multi-cycle operation. Binary operations complete in one cycle. It sits between the datapath operand registers and the flag/result latches, and holds its result and flags until the next operation completes.

## Interface
- `WIDTH`, default 8: datapath width; must be a multiple of 4 and ≥ 8. `N = WIDTH/4` BCD digits.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted only when `busy=0`.
- `op` in 4: opcode, sampled with `start`.
- `a`, `b` in WIDTH: operands, sampled with `start`.
- `c_in` in 1: carry in, sampled with `start`.
- `bcd` in 1: decimal mode, sampled with `start`; affects only ops 2 and 3.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; results valid from this cycle on.
- `y` out WIDTH: registered result.
- `c_out`, `zero`, `negative`, `overflow` out 1: registered flags.

## Operation
- Reset: state IDLE; `busy`, `done`, `y`, `c_out`, `zero`, `negative`, `overflow` all 0. Reset mid-operation aborts it, and no `done` is produced.
- States:
  - IDLE: `start` goes to CALC (binary op) or BCD (op 2/3 with `bcd=1`). Operands are latched on the accepting edge.
  - CALC: 1 cycle, then DONE.
  - BCD: digit counter `k = 0..N-1`, one nibble per cycle, LSB first; after digit N-1, go to DONE.
  - DONE: `done=1` for one cycle. `start` is accepted here too (back-to-back); otherwise return to IDLE.
- `start` while `busy=1` is ignored; the latched operands are unaffected.
- Opcodes. "ri" below means `result_in`: the carry/rotate input bit.
  - 0 inc: `{c,y} = a + c_in`.
  - 1 dec: `{c,y} = a - c_in`; c=1 on borrow.
  - 2 add: `{c,y} = a + b + c_in`.
  - 3 sub: `{c,y} = b + ~a + c_in`, i.e. `b - a - !c_in`; c=1 means no borrow.
  - 4 ror: `y = {ri, a[W-1:1]}` with ri = `c_in`; c = `a[0]`.
  - 5 asl: `y = {a[W-2:0], 0}`; c = `a[W-1]`.
  - 6 rol: `y = {a[W-2:0], c_in}`; c = `a[W-1]`.
  - 7 or, 8 and, A eor: bitwise on a,b; c = 0.
  - 9 bit test: `y = a & b`; c = 0.
  - B ones: `y` = all ones; c = 1.
  - C lsr: `y = {0, a[W-1:1]}`; c = `a[0]`.
  - D–F: `y = 0`, c = 0.
- BCD add, digit k: `s = a_k + b_k + cy`; if `s > 9` then `s = s + 6` and `cy = 1`, else `cy = 0`. Digit = `s[3:0]`. Initial `cy = c_in`; final `c_out = cy`.
- BCD sub, digit k: `d = b_k - a_k - br`; if `d < 0` then `d = d + 10` and `br = 1`, else `br = 0`. Digit = `d[3:0]`. Initial `br = !c_in`; final `c_out = !br`.
- Non-decimal digits (>9) run through the same rules; no error is flagged.
- Flags, registered with `y`:
  - `zero = (y == 0)`.
  - `negative = y[W-1] | (op==9 & a[W-1])`.
  - `overflow`:
    - ops 2/3: carry into MSB XOR carry out of the binary sum `a' + b + c_in`, where `a' = ~a` for sub. This uses the binary sum even when `bcd=1`.
    - op 9: `a[W-2]`.
    - otherwise: 0.

## Timing
- `start` is accepted at edge T.
- Binary ops: `y`/flags update and `done=1` after edge T+1; `busy=1` only between T and T+1.
- BCD ops: digit k is written at edge T+1+k. `y`/flags are final and `done=1` after edge T+N; `busy=1` from T until T+N.
- Throughput: a new `start` in the DONE cycle gives back-to-back ops, latency 1 (binary) or N (BCD) each.
- Partial BCD digits may appear in `y` while `busy=1`. Flags change only on the `done` edge.
- Outputs hold their values between operations.

## Test plan
- WIDTH=8, binary add, a=0x50 b=0x50 c_in=0 → `done` one cycle after start; y=0xA0, c=0, V=1, N=1, Z=0.
- WIDTH=8, BCD add, a=0x58 b=0x46 c_in=1 → `busy` 2 cycles; y=0x05, c=1, Z=0.
- WIDTH=8, BCD sub, a=0x21 b=0x12 c_in=1 → y=0x91, c=0. Then binary sub, a=0x01 b=0x10 c_in=1 → y=0x0F, c=1.
- WIDTH=16, BCD add, a=0x0001 b=0x9999 c_in=0 → `done` after 4 cycles; y=0x0000, c=1, Z=1. A `start` pulsed mid-op is ignored.
- ror a=0x01 c_in=1 → y=0x80, c=1, N=1. Bit test a=0xC0 b=0x00 → y=0, Z=1, N=1, V=1.
- Reset asserted at digit 1 of a WIDTH=16 BCD op → all outputs 0 immediately, no `done`. A fresh `start` after release completes normally.
